// File: rtl/isp_program_loader.sv
// isp_program_loader: streams a program image from a valid/ready word source
// into the RISC_V_Core in-system-programming port, then issues the core start
// pulse with the captured entry address.
//
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   load_req                     begin a load session (honoured in IDLE/DONE/ERROR)
//   base_address, entry_address  first word address / start PC, sampled on load_req
//   in_valid, in_ready           word handshake (in_ready decoded from state)
//   in_data, in_last             program word and end-of-image marker
//   isp_write/address/data       registered program-memory write to the core
//   start, prog_address          one-cycle start pulse and start PC
//   busy, done, overflow         session status (done/overflow sticky until next load)
//   word_count                   words written this session
module isp_program_loader #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDRESS_BITS   = 12,
   parameter int unsigned PROG_ADDR_BITS = 20,
   parameter int unsigned SETTLE_CYCLES  = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      load_req,
   input  logic [ADDRESS_BITS-1:0]   base_address,
   input  logic [PROG_ADDR_BITS-1:0] entry_address,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     in_data,
   input  logic                      in_last,
   output logic                      isp_write,
   output logic [ADDRESS_BITS-1:0]   isp_address,
   output logic [DATA_WIDTH-1:0]     isp_data,
   output logic                      start,
   output logic [PROG_ADDR_BITS-1:0] prog_address,
   output logic                      busy,
   output logic                      done,
   output logic                      overflow,
   output logic [ADDRESS_BITS:0]     word_count
);

   localparam int unsigned CNT_W = ADDRESS_BITS + 1;
   localparam int unsigned SET_W = 8;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SETTLE, S_START, S_DONE, S_ERROR
   } state_e;

   state_e                    state_q, state_d;
   logic [ADDRESS_BITS-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]          count_q, count_d;
   logic [SET_W-1:0]          settle_q, settle_d;
   logic [PROG_ADDR_BITS-1:0] entry_q, entry_d;
   logic                      wr_q, wr_d;
   logic [ADDRESS_BITS-1:0]   waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic [PROG_ADDR_BITS-1:0] paddr_q, paddr_d;

   logic idle_like;
   logic accept_load;
   logic hs;

   assign idle_like   = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
   assign accept_load = load_req && idle_like;
   assign hs          = in_valid && in_ready;

   // State register
   always_ff @(posedge clock) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: if (load_req) state_d = S_LOAD;
         S_LOAD: begin
            if (hs) begin
               if (in_last)            state_d = S_SETTLE;
               else if (&ptr_q)        state_d = S_ERROR;   // top word written, image not finished
            end
         end
         S_SETTLE: if (settle_q <= SET_W'(1)) state_d = S_START;
         S_START:  state_d = S_DONE;
         default:  state_d = S_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      overflow = 1'b0;
      start    = 1'b0;
      case (state_q)
         S_LOAD:   begin in_ready = 1'b1; busy = 1'b1; end
         S_SETTLE: busy = 1'b1;
         S_START:  begin busy = 1'b1; start = 1'b1; end
         S_DONE:   done = 1'b1;
         S_ERROR:  overflow = 1'b1;
         default:  ;
      endcase
   end

   // Datapath next-state: pointer, counters, write port, start address
   always_comb begin
      ptr_d    = ptr_q;
      count_d  = count_q;
      settle_d = settle_q;
      entry_d  = entry_q;
      wr_d     = hs;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      paddr_d  = paddr_q;
      if (accept_load) begin
         ptr_d   = base_address;
         entry_d = entry_address;
         count_d = '0;
         paddr_d = '0;
      end
      if (hs) begin
         waddr_d = ptr_q;
         wdata_d = in_data;
         ptr_d   = ptr_q + ADDRESS_BITS'(1);
         count_d = count_q + CNT_W'(1);
         if (in_last) settle_d = SET_W'(SETTLE_CYCLES);
      end
      if (state_q == S_SETTLE) begin
         settle_d = settle_q - SET_W'(1);
         if (state_d == S_START) paddr_d = entry_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q    <= '0;
         count_q  <= '0;
         settle_q <= '0;
         entry_q  <= '0;
         wr_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         paddr_q  <= '0;
      end else begin
         ptr_q    <= ptr_d;
         count_q  <= count_d;
         settle_q <= settle_d;
         entry_q  <= entry_d;
         wr_q     <= wr_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         paddr_q  <= paddr_d;
      end
   end

   assign isp_write    = wr_q;
   assign isp_address  = waddr_q;
   assign isp_data     = wdata_q;
   assign prog_address = paddr_q;
   assign word_count   = count_q;

endmodule

// File: tb/tb_isp_program_loader.sv
// Scoreboard bench for isp_program_loader: stimulus pushes expected isp writes
// and start events; a negedge monitor pops and compares whenever the DUT
// presents a write or a start pulse.
module tb_isp_program_loader;

   logic        clock = 1'b0;
   logic        reset;
   logic        load_req;
   logic [11:0] base_address;
   logic [19:0] entry_address;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        isp_write;
   logic [11:0] isp_address;
   logic [31:0] isp_data;
   logic        start;
   logic [19:0] prog_address;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [12:0] word_count;

   isp_program_loader dut (
      .clock(clock), .reset(reset), .load_req(load_req),
      .base_address(base_address), .entry_address(entry_address),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .isp_write(isp_write), .isp_address(isp_address), .isp_data(isp_data),
      .start(start), .prog_address(prog_address),
      .busy(busy), .done(done), .overflow(overflow), .word_count(word_count)
   );

   always #5 clock = ~clock;

   typedef struct { logic [11:0] a; logic [31:0] d; } wr_t;
   wr_t         wq[$];
   logic [19:0] sq[$];
   wr_t         mon_e;
   logic [19:0] mon_p;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int last_wr = -100;
   logic [11:0] exp_ptr;
   logic [19:0] exp_entry;

   logic [31:0] img [4];
   initial begin
      img[0] = 32'h00100513; img[1] = 32'h00300593;
      img[2] = 32'h80000637; img[3] = 32'h7ffff6b7;
   end

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: compare every write and every start pulse against the scoreboard
   always @(negedge clock) begin
      if (isp_write === 1'b1) begin
         if (wq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write", isp_address, isp_data);
         end else begin
            mon_e = wq.pop_front();
            chk("write_addr", 64'(isp_address), 64'(mon_e.a));
            chk("write_data", 64'(isp_data), 64'(mon_e.d));
         end
         last_wr = cyc;
      end
      if (start === 1'b1) begin
         chk("start_no_overlap", 64'(isp_write), 64'd0);
         if (sq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_start: got start with prog_address %0h expected no start", prog_address);
         end else begin
            mon_p = sq.pop_front();
            chk("prog_address_at_start", 64'(prog_address), 64'(mon_p));
            chk("start_latency", 64'(cyc - last_wr), 64'd2);
         end
      end
   end

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic do_load(input logic [11:0] base, input logic [19:0] entry);
      load_req = 1'b1; base_address = base; entry_address = entry;
      tick();
      load_req = 1'b0;
      chk("busy_after_load", 64'(busy), 64'd1);
      chk("done_cleared", 64'(done), 64'd0);
      exp_ptr   = base;
      exp_entry = entry;
   endtask

   task automatic send(input logic [31:0] d, input logic last, input logic gap);
      int n = 0;
      in_valid = 1'b1; in_data = d; in_last = last;
      while (!in_ready && n < 20) begin tick(); n++; end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout: got in_ready 0 expected 1 for word %0h", d);
         in_valid = 1'b0; in_last = 1'b0;
         return;
      end
      wq.push_back('{exp_ptr, d});
      exp_ptr = exp_ptr + 12'd1;
      if (last) sq.push_back(exp_entry);
      tick();
      in_valid = 1'b0; in_last = 1'b0; in_data = 32'hDEADBEEF;
      if (gap) tick();
   endtask

   task automatic wait_end();
      int n = 0;
      while (!(done || overflow) && n < 30) begin tick(); n++; end
      if (!(done || overflow)) begin
         checks++; errors++;
         $display("FAIL wait_end_timeout: got done 0 overflow 0 expected one of them set");
      end
   endtask

   task automatic send_image(input logic gap);
      for (int i = 0; i < 4; i++) send(img[i], (i == 3), gap);
   endtask

   initial begin
      reset = 1'b1; load_req = 1'b0; base_address = '0; entry_address = '0;
      in_valid = 1'b0; in_data = '0; in_last = 1'b0;

      // 1: reset held with inputs toggling
      for (int i = 0; i < 3; i++) begin
         load_req = 1'(i); in_valid = 1'b1; in_last = 1'(i);
         in_data = $urandom; base_address = 12'(i * 7); entry_address = 20'(i * 13);
         tick();
         chk("rst_flags", 64'({in_ready, isp_write, start, busy, done, overflow}), 64'd0);
         chk("rst_addr_data", 64'({isp_address, isp_data}), 64'd0);
         chk("rst_prog_count", 64'({prog_address, word_count}), 64'd0);
      end
      load_req = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      reset = 1'b0;
      tick();

      // 2: back-to-back image at address 0
      do_load(12'h000, 20'h00000);
      send_image(1'b0);
      wait_end();
      chk("t2_done", 64'(done), 64'd1);
      chk("t2_word_count", 64'(word_count), 64'd4);
      chk("t2_prog_address", 64'(prog_address), 64'd0);
      chk("t2_idle_ready_busy", 64'({in_ready, busy}), 64'd0);

      // 3: same image with bubbles on in_valid
      do_load(12'h000, 20'h00000);
      send_image(1'b1);
      wait_end();
      chk("t3_done", 64'(done), 64'd1);
      chk("t3_word_count", 64'(word_count), 64'd4);

      // 4: overflow at top of program memory
      do_load(12'hFFE, 20'h00123);
      send(32'h11111111, 1'b0, 1'b0);
      send(32'h22222222, 1'b0, 1'b0);
      in_valid = 1'b1; in_data = 32'h33333333;
      for (int i = 0; i < 3; i++) begin
         chk("t4_in_ready_low", 64'(in_ready), 64'd0);
         tick();
      end
      in_valid = 1'b0;
      chk("t4_overflow", 64'(overflow), 64'd1);
      chk("t4_word_count", 64'(word_count), 64'd2);
      chk("t4_done_busy", 64'({done, busy}), 64'd0);

      // 5: reset mid-session, then a clean reload
      do_load(12'h100, 20'h00200);
      send(img[0], 1'b0, 1'b0);
      send(img[1], 1'b0, 1'b0);
      reset = 1'b1; in_valid = 1'b1; in_data = img[2];
      tick();
      chk("t5_rst_flags", 64'({in_ready, isp_write, start, busy, done, overflow}), 64'd0);
      reset = 1'b0; in_valid = 1'b0;
      tick(); tick();
      chk("t5_idle", 64'({busy, done, overflow, start}), 64'd0);
      do_load(12'h100, 20'h00200);
      send_image(1'b0);
      wait_end();
      chk("t5_done", 64'(done), 64'd1);
      chk("t5_word_count", 64'(word_count), 64'd4);

      // 6: load_req ignored mid-LOAD; reload from DONE with new entry
      do_load(12'h010, 20'h00777);
      send(img[0], 1'b0, 1'b0);
      send(img[1], 1'b0, 1'b0);
      load_req = 1'b1; base_address = 12'h300; entry_address = 20'h00999;
      tick();
      load_req = 1'b0;
      chk("t6_count_kept", 64'(word_count), 64'd2);
      chk("t6_busy_kept", 64'(busy), 64'd1);
      send(img[2], 1'b0, 1'b0);
      send(img[3], 1'b1, 1'b0);
      wait_end();
      chk("t6_word_count", 64'(word_count), 64'd4);
      chk("t6_prog_address", 64'(prog_address), 64'h777);
      do_load(12'h020, 20'h00040);
      send(32'hCAFEF00D, 1'b1, 1'b0);
      wait_end();
      chk("t6b_done", 64'(done), 64'd1);
      chk("t6b_word_count", 64'(word_count), 64'd1);
      chk("t6b_prog_address", 64'(prog_address), 64'h40);

      tick(); tick();
      chk("writes_drained", 64'(wq.size()), 64'd0);
      chk("starts_drained", 64'(sq.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/isp_program_loader.md
Name: isp_program_loader

Overview:
- Upstream feeder for RISC_V_Core: streams a program image over a valid/ready word interface into the core's in-system-programming port (isp_write/isp_address/isp_data).
- On completion, issues the one-cycle start pulse with prog_address, replacing the behavioural $readmemh + start sequence the instruction tests use today.
- Sits between a host/UART/bench word source and the core. Synthesizable.

Parameters:
DATA_WIDTH, 32, width of program words and isp_data
ADDRESS_BITS, 12, width of isp_address (word address into program memory)
PROG_ADDR_BITS, 20, width of prog_address / entry_address
SETTLE_CYCLES, 2, idle cycles between the final isp write and start; legal range 1..255

Ports:
clock  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high
load_req  input  1  one-cycle request to begin a load session; honoured only in IDLE/DONE/ERROR
base_address  input  ADDRESS_BITS  first word address, sampled on an accepted load_req
entry_address  input  PROG_ADDR_BITS  start PC, sampled on an accepted load_req
in_valid  input  1  source word valid
in_ready  output  1  loader accepts a word this cycle
in_data  input  DATA_WIDTH  program word
in_last  input  1  marks final word of the image; qualified by in_valid
isp_write  output  1  program-memory write strobe to core
isp_address  output  ADDRESS_BITS  write word address
isp_data  output  DATA_WIDTH  write data
start  output  1  one-cycle core start pulse
prog_address  output  PROG_ADDR_BITS  start PC presented to core
busy  output  1  session in progress (LOAD/SETTLE/START)
done  output  1  sticky: last session completed and start issued
overflow  output  1  sticky: image ran past top of program memory
word_count  output  ADDRESS_BITS+1  words written this session

Behaviour:
- Reset (sync, high): state IDLE; all outputs 0 (in_ready, isp_write, isp_address, isp_data, start, prog_address, busy, done, overflow, word_count). Reset mid-session aborts at that edge: no further isp writes, no start.
- States: IDLE, LOAD, SETTLE, START, DONE, ERROR.
- IDLE/DONE/ERROR + load_req: capture base_address into write pointer, entry_address into entry register; clear word_count, done, overflow; go LOAD. load_req in LOAD/SETTLE/START ignored.
- LOAD: in_ready=1 combinationally from state (not from in_valid). Handshake = in_valid & in_ready at edge T:
  - Cycle T+1: isp_write=1, isp_address=pointer, isp_data=in_data (registered, 1-cycle latency). Otherwise isp_write=0.
  - Pointer +1, word_count +1.
  - in_last=1: go SETTLE, counter=SETTLE_CYCLES.
  - in_last=0 with pointer at all-ones (top address): word is still written; overflow=1, go ERROR. Pointer never wraps to issue a write at 0.
- Back-to-back handshakes allowed; one word per cycle max; addresses strictly contiguous regardless of in_valid bubbles.
- SETTLE: in_ready=0. Decrement each cycle; exit to START after exactly SETTLE_CYCLES cycles. First SETTLE cycle coincides with the final isp_write.
- START: start=1 for exactly this cycle; prog_address=entry register (zero-extended or truncated to PROG_ADDR_BITS). Go DONE.
- prog_address is registered and holds the entry value after start until the next accepted load_req or reset.
- DONE: done=1, busy=0, in_ready=0. ERROR: overflow=1, busy=0, in_ready=0, start never asserted.
- busy=1 exactly in LOAD, SETTLE, START.
- Timing: last word handshake at edge T gives final isp_write in cycle T+1 and start in cycle T+1+SETTLE_CYCLES. start never overlaps isp_write.
- Single-word image (in_last on first word) is legal.
- word_count saturates naturally: max 2^ADDRESS_BITS.

Test Plan:
1. Reset held 3 cycles, all inputs toggling -> all outputs 0, no isp_write, no start.
2. load_req, base=0x000, entry=0x00000; four words 0x00100513, 0x00300593, 0x80000637, 0x7ffff6b7 back-to-back, last on 4th -> isp writes at addresses 0..3 with those data in consecutive cycles; start high exactly 2 cycles after the 4th write cycle; prog_address=0; done=1; word_count=4.
3. Same image with in_valid low every other cycle -> writes only on handshakes, addresses 0..3 contiguous, identical final memory image, start 2 cycles after last write.
4. base=0xFFE, three words, no in_last -> writes at 0xFFE and 0xFFF only; overflow=1, in_ready=0, third word never accepted, start never asserted, word_count=2.
5. Reset asserted after 2 of 4 words accepted -> isp_write 0 from next cycle, no start, state IDLE; fresh load_req then loads a full image correctly.
6. load_req pulsed mid-LOAD -> ignored (pointer and word_count unaffected). load_req in DONE with entry=0x00040 -> done clears, new session runs, prog_address=0x00040 at start.
